// File: rtl/hdlc_pkg.sv
// Shared HDLC framing constants, FSM state type and FCS-16 / escape helpers.
package hdlc_pkg;

  localparam logic [7:0]  FLAG     = 8'h7E;
  localparam logic [7:0]  ESC      = 8'h7D;
  localparam logic [7:0]  XOR      = 8'h20;

  localparam logic [15:0] FCS_INIT = 16'hFFFF;
  localparam logic [15:0] FCS_POLY = 16'h8408;
  // Residual of a good frame, for the receive-side decoder.
  localparam logic [15:0] FCS_GOOD = 16'hF0B8;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    FCS_LO,
    FCS_HI,
    CLOSE
  } state_t;

  // One byte of reflected CRC-16/X-25, LSB first.
  function automatic logic [15:0] fcs_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ FCS_POLY;
      else      c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic needs_escape(input logic [7:0] b, input logic ctrl);
    return (b == FLAG) || (b == ESC) || (ctrl && (b < 8'h20));
  endfunction

endpackage

// File: rtl/hdlc_frame_tx_fcs16.sv
// Byte-wide CRC-16/X-25 accumulator with synchronous clear and update enable.
module fcs16
  import hdlc_pkg::*;
(
  input  logic        mclk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // CRC register: clear has priority over an update.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset)       crc <= FCS_INIT;
    else if (clear)  crc <= FCS_INIT;
    else if (enable) crc <= fcs_update(crc, data);
  end

endmodule

// File: rtl/hdlc_frame_tx.sv
// HDLC transmit framer: flag, byte-stuffed payload, FCS-16, flag, fed to a UART byte transmitter.
module hdlc_frame_tx
  import hdlc_pkg::*;
#(
  parameter int unsigned ESCAPE_CTRL = 0
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] uart_data,
  output logic       uart_strobe,
  input  logic       uart_ready,
  output logic       busy
);

  localparam logic CTRL = (ESCAPE_CTRL != 0);

  state_t      state, state_n;
  logic        pend, pend_n;
  logic [7:0]  pend_byte, pend_byte_n;
  logic        pend_last, pend_last_n;
  logic        strobe_d1;
  logic        strobe_n;
  logic [7:0]  data_n;
  logic [15:0] crc;
  logic [15:0] fcs;
  logic        can_send;
  logic        accept;

  logic [7:0]  cur_byte;
  logic        cur_go;
  logic        cur_last;
  state_t      after;

  // The UART's ready stays stale for a cycle after a load, so two strobe-free cycles are required.
  assign can_send = uart_ready && !uart_strobe && !strobe_d1;
  assign in_ready = (state == DATA) && can_send && !pend;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign fcs      = ~crc;

  fcs16 u_fcs (
    .mclk   (mclk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (accept),
    .data   (in_data),
    .crc    (crc)
  );

  // Next-state and output decode; DATA/FCS_LO/FCS_HI share one escape path
  // that advances state only once both halves of an escaped byte are out.
  always_comb begin
    state_n     = state;
    pend_n      = pend;
    pend_byte_n = pend_byte;
    pend_last_n = pend_last;
    strobe_n    = 1'b0;
    data_n      = uart_data;

    cur_byte = in_data;
    cur_go   = in_valid && can_send;
    cur_last = in_last;
    after    = FCS_LO;
    case (state)
      FCS_LO: begin
        cur_byte = fcs[7:0];
        cur_go   = can_send;
        cur_last = 1'b1;
        after    = FCS_HI;
      end
      FCS_HI: begin
        cur_byte = fcs[15:8];
        cur_go   = can_send;
        cur_last = 1'b1;
        after    = CLOSE;
      end
      default: ;
    endcase

    case (state)
      IDLE: begin
        if (in_valid && can_send) begin
          strobe_n = 1'b1;
          data_n   = FLAG;
          state_n  = DATA;
        end
      end
      DATA, FCS_LO, FCS_HI: begin
        if (pend) begin
          if (can_send) begin
            strobe_n = 1'b1;
            data_n   = pend_byte;
            pend_n   = 1'b0;
            if (pend_last) state_n = after;
          end
        end else if (cur_go) begin
          strobe_n = 1'b1;
          if (needs_escape(cur_byte, CTRL)) begin
            data_n      = ESC;
            pend_n      = 1'b1;
            pend_byte_n = cur_byte ^ XOR;
            pend_last_n = cur_last;
          end else begin
            data_n = cur_byte;
            if (cur_last) state_n = after;
          end
        end
      end
      CLOSE: begin
        if (can_send) begin
          strobe_n = 1'b1;
          data_n   = FLAG;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, escape-pending and registered UART outputs.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= 1'b0;
      pend_byte   <= '0;
      pend_last   <= 1'b0;
      uart_strobe <= 1'b0;
      uart_data   <= '0;
      strobe_d1   <= 1'b0;
    end else begin
      state       <= state_n;
      pend        <= pend_n;
      pend_byte   <= pend_byte_n;
      pend_last   <= pend_last_n;
      uart_strobe <= strobe_n;
      uart_data   <= data_n;
      strobe_d1   <= uart_strobe;
    end
  end

endmodule

// File: tb/tb_hdlc_frame_tx.sv
// Self-checking bench for hdlc_frame_tx: vector table, hand sequences and randomized frames
// against a byte-queue frame model.
module tb_hdlc_frame_tx;

  localparam int UART_BUSY = 20;

  logic       mclk;
  logic       reset;
  logic [7:0] in_data     [2];
  logic       in_valid    [2];
  logic       in_last     [2];
  logic       in_ready    [2];
  logic [7:0] uart_data   [2];
  logic       uart_strobe [2];
  logic       uart_ready  [2];
  logic       busy        [2];

  bit         ready_mode;   // 1: UART always ready, 0: busy UART_BUSY cycles per byte
  int         ucnt [2];
  int         cyc;
  int         last_cyc [2];
  logic [7:0] cap [2][$];
  logic [7:0] exp_q [$];
  int         n_pass, n_total;

  hdlc_frame_tx #(.ESCAPE_CTRL(0)) dut0 (
    .mclk(mclk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .uart_data(uart_data[0]),
    .uart_strobe(uart_strobe[0]), .uart_ready(uart_ready[0]), .busy(busy[0]));

  hdlc_frame_tx #(.ESCAPE_CTRL(1)) dut1 (
    .mclk(mclk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .uart_data(uart_data[1]),
    .uart_strobe(uart_strobe[1]), .uart_ready(uart_ready[1]), .busy(busy[1]));

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // UART transmitter model: ready stays high during the load cycle, then drops.
  always @(posedge mclk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (uart_strobe[k])   ucnt[k] <= UART_BUSY;
      else if (ucnt[k] > 0) ucnt[k] <= ucnt[k] - 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) uart_ready[k] = ready_mode ? 1'b1 : (ucnt[k] == 0);
  end

  // Capture every strobed byte and check strobe spacing.
  always @(negedge mclk) begin
    for (int k = 0; k < 2; k++) begin
      if (uart_strobe[k]) begin
        cap[k].push_back(uart_data[k]);
        check("strobe_spacing", ((cyc - last_cyc[k]) >= 3), 1);
        last_cyc[k] = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 16'h8408;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  function automatic void push_esc(input logic [7:0] b, input bit ctrl);
    if (b == 8'h7E || b == 8'h7D || (ctrl && b < 8'h20)) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  function automatic void append_frame(input logic [0:15][7:0] pay, input int n, input bit ctrl);
    logic [15:0] c, f;
    c = 16'hFFFF;
    exp_q.push_back(8'h7E);
    for (int i = 0; i < n; i++) begin
      c = ref_crc(c, pay[i]);
      push_esc(pay[i], ctrl);
    end
    f = ~c;
    push_esc(f[7:0], ctrl);
    push_esc(f[15:8], ctrl);
    exp_q.push_back(8'h7E);
  endfunction

  // ---------------- drivers ----------------
  task automatic send_bytes(input int sel, input logic [0:15][7:0] pay, input int n,
                            input int gap_at, input int gap_len);
    int t, s0;
    for (int i = 0; i < n; i++) begin
      in_data[sel]  = pay[i];
      in_last[sel]  = (i == n - 1);
      in_valid[sel] = 1'b1;
      t = 0;
      while (1) begin
        @(negedge mclk);
        if (in_ready[sel]) break;
        t++;
        if (t > 3000) begin
          check("accept_timeout", 0, 1);
          in_valid[sel] = 1'b0;
          return;
        end
      end
      @(posedge mclk);
      #1;
      if (i == gap_at && gap_len > 3) begin
        in_valid[sel] = 1'b0;
        repeat (3) @(posedge mclk);
        s0 = cap[sel].size();
        repeat (gap_len - 3) @(posedge mclk);
        check("gap_quiet", cap[sel].size(), s0);
        check("gap_busy", busy[sel], 1);
        #1;
      end
    end
    in_valid[sel] = 1'b0;
    in_last[sel]  = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int t;
    t = 0;
    while (1) begin
      @(negedge mclk);
      if (!busy[sel]) break;
      t++;
      if (t > 5000) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
    repeat (2) @(negedge mclk);
  endtask

  task automatic compare_cap(input int sel, input logic [0:15][7:0] pre, input int prelen);
    int m;
    check("frame_len", cap[sel].size(), exp_q.size());
    m = (cap[sel].size() < exp_q.size()) ? cap[sel].size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("byte[%0d]", i), cap[sel][i], exp_q[i]);
    for (int i = 0; i < prelen && i < cap[sel].size(); i++)
      check($sformatf("literal[%0d]", i), cap[sel][i], pre[i]);
    cap[sel].delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [0:15][7:0] pay;
    logic [7:0]       plen;
    logic [0:15][7:0] pre;
    logic [7:0]       prelen;
    logic             sel;
    logic             rdy_hi;
    logic [7:0]       gap_at;
    logic [7:0]       gap_len;
  } vec_t;

  vec_t vec [6];

  initial begin
    logic [0:15][7:0] p, q;
    int n, n2, sel;

    n_pass = 0; n_total = 0; cyc = 0;
    ready_mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ucnt[k] = 0; last_cyc[k] = -100;
      in_data[k] = '0; in_valid[k] = 1'b0; in_last[k] = 1'b0;
    end

    vec[0] = '{pay: {8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,{7{8'h00}}}, plen: 9,
               pre: {8'h7E,8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h6E,8'h90,8'h7E,{3{8'h00}}},
               prelen: 13, sel: 0, rdy_hi: 0, gap_at: 8'hFF, gap_len: 0};
    vec[1] = '{pay: {8'h7E,8'h7D,{14{8'h00}}}, plen: 2,
               pre: {8'h7E,8'h7D,8'h5E,8'h7D,8'h5D,{11{8'h00}}}, prelen: 5,
               sel: 0, rdy_hi: 0, gap_at: 8'hFF, gap_len: 0};
    vec[2] = '{pay: {8'h11,{15{8'h00}}}, plen: 1,
               pre: {8'h7E,8'h7D,8'h31,{13{8'h00}}}, prelen: 3,
               sel: 1, rdy_hi: 0, gap_at: 8'hFF, gap_len: 0};
    vec[3] = '{pay: {8'h11,{15{8'h00}}}, plen: 1,
               pre: {8'h7E,8'h11,{14{8'h00}}}, prelen: 2,
               sel: 0, rdy_hi: 0, gap_at: 8'hFF, gap_len: 0};
    vec[4] = '{pay: {8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,{10{8'h00}}}, plen: 6,
               pre: {8'h7E,8'h01,{14{8'h00}}}, prelen: 2,
               sel: 0, rdy_hi: 1, gap_at: 2, gap_len: 50};
    vec[5] = '{pay: {8'h7D,8'h00,8'h7E,{13{8'h00}}}, plen: 3,
               pre: {8'h7E,8'h7D,8'h5D,8'h7D,8'h20,8'h7D,8'h5E,{9{8'h00}}}, prelen: 7,
               sel: 1, rdy_hi: 1, gap_at: 8'hFF, gap_len: 0};

    // Reset state
    reset = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", in_ready[k], 0);
      check("rst_strobe", uart_strobe[k], 0);
      check("rst_data", uart_data[k], 8'h00);
      check("rst_busy", busy[k], 0);
    end
    repeat (3) @(posedge mclk);
    #1 reset = 1'b0;
    repeat (2) @(posedge mclk);
    #1;

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      ready_mode = vec[v].rdy_hi;
      exp_q.delete();
      append_frame(vec[v].pay, int'(vec[v].plen), vec[v].sel);
      send_bytes(int'(vec[v].sel), vec[v].pay, int'(vec[v].plen),
                 int'(vec[v].gap_at), int'(vec[v].gap_len));
      wait_idle(int'(vec[v].sel));
      compare_cap(int'(vec[v].sel), vec[v].pre, int'(vec[v].prelen));
    end

    // Back-to-back frames: each with its own flags and FCS
    ready_mode = 1'b0;
    p = '0; q = '0;
    p[0:2] = {8'hA1, 8'h7E, 8'h42};
    q[0:3] = {8'h10, 8'h20, 8'h7D, 8'hFF};
    exp_q.delete();
    append_frame(p, 3, 0);
    append_frame(q, 4, 0);
    send_bytes(0, p, 3, -1, 0);
    send_bytes(0, q, 4, -1, 0);
    wait_idle(0);
    compare_cap(0, '0, 0);

    // Reset during a payload byte
    ready_mode = 1'b0;
    in_data[0] = 8'h55; in_last[0] = 1'b0; in_valid[0] = 1'b1;
    n = 0;
    while (n < 4000) begin
      @(negedge mclk);
      if (cap[0].size() >= 3 && uart_strobe[0]) break;
      n++;
    end
    check("reset_window_found", (n < 4000), 1);
    #1 reset = 1'b1;
    in_valid[0] = 1'b0;
    #1;
    check("midrst_strobe", uart_strobe[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_in_ready", in_ready[0], 0);
    repeat (3) @(posedge mclk);
    #1 reset = 1'b0;
    repeat (2) @(posedge mclk);
    cap[0].delete();
    p = '0;
    p[0:2] = {8'h55, 8'h7E, 8'h12};
    exp_q.delete();
    append_frame(p, 3, 0);
    send_bytes(0, p, 3, -1, 0);
    wait_idle(0);
    compare_cap(0, {8'h7E, {15{8'h00}}}, 1);

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(0, 1);
      ready_mode = $urandom_range(0, 1);
      n2 = $urandom_range(1, 12);
      p = '0;
      for (int i = 0; i < n2; i++) begin
        case ($urandom_range(0, 7))
          0: p[i] = 8'h7E;
          1: p[i] = 8'h7D;
          2: p[i] = 8'($urandom_range(0, 31));
          default: p[i] = 8'($urandom_range(0, 255));
        endcase
      end
      exp_q.delete();
      append_frame(p, n2, sel[0]);
      send_bytes(sel, p, n2, -1, 0);
      wait_idle(sel);
      compare_cap(sel, '0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
